// File: rtl/amba_axi_pkg.sv
// Shared AXI3 constants and FSM state type for the amba_axi_read / amba_axi_write initiators.
package amba_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] LOCK_NORMAL   = 2'b00;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0001;
    localparam logic [2:0] PROT_DEFAULT  = 3'b010;
    localparam logic [2:0] SIZE_4B       = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } axi_state_e;

endpackage

// File: rtl/amba_axi_read_ostage.sv
// Single-entry valid/ready output register carrying one R beat (data + last).
module amba_axi_read_ostage #(
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
);

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic              last_p1;

    // Accept when empty or when the held beat drains this cycle.
    assign in_ready = !vld_p1 || out_ready;

    // Stage p1: output register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (in_valid && in_ready) begin
            vld_p1  <= 1'b1;
            data_p1 <= in_data;
            last_p1 <= in_last;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_last  = last_p1;

endmodule

// File: rtl/amba_axi_read.sv
// AXI3 read initiator: one burst at a time, AR issue, R collection into a registered output stage.
module amba_axi_read
    import amba_axi_pkg::*;
#(
    parameter logic [3:0] ARID = 4'h0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_len,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic [2:0]  err
);

    axi_state_e state;
    logic [4:0] cnt;
    logic       ost_ready;
    logic       beat;
    logic       len_hit;

    function automatic logic [4:0] sat_inc(input logic [4:0] c);
        return (c == 5'd16) ? c : c + 5'd1;
    endfunction

    assign arid    = ARID;
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;
    assign arlock  = LOCK_NORMAL;
    assign arcache = CACHE_DEFAULT;
    assign arprot  = PROT_DEFAULT;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rready    = (state == ST_DATA) && ost_ready;
    assign beat      = rvalid && rready;
    assign len_hit   = (cnt == {1'b0, arlen});

    // Burst completion follows rlast; the counter only feeds the length check.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= ST_IDLE;
            arvalid <= 1'b0;
            araddr  <= '0;
            arlen   <= '0;
            cnt     <= '0;
            err     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        araddr  <= req_addr;
                        arlen   <= req_len;
                        cnt     <= '0;
                        err     <= '0;
                        arvalid <= 1'b1;
                        state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        cnt    <= sat_inc(cnt);
                        err[0] <= err[0] | (rresp != RESP_OKAY);
                        err[1] <= err[1] | (rid != ARID);
                        err[2] <= err[2] | (rlast != len_hit);
                        if (rlast) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    amba_axi_read_ostage #(.DATA_W(32)) u_ostage (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (beat),
        .in_data   (rdata),
        .in_last   (rlast),
        .in_ready  (ost_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

endmodule

// File: doc/amba_axi_read.md
# amba_axi_read

AXI3 read-channel initiator for the Brazil-IP AAC decoder; the read-side counterpart of `amba_axi_write`. It takes one burst request at a time from the decoder core, drives the AR channel and collects R beats. Beats are forwarded through a registered output stage with valid/ready flow control. Response, ID and last-beat errors are collected in sticky status bits.

## Interface
Parameters:
- `ARID`, 4'h0: constant transaction ID driven on `arid` and expected on `rid`.

Ports:
- `aclk` input 1: clock; all logic is on the rising edge.
- `aresetn` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: burst request valid.
- `req_ready` output 1: request accepted when both are high. Equals state==IDLE.
- `req_addr` input 32: burst start byte address, word aligned.
- `req_len` input 4: beats minus 1 (1–16 beats).
- `arid` output 4: = `ARID`.
- `araddr` output 32: latched `req_addr`.
- `arlen` output 4: latched `req_len`.
- `arsize` output 3: constant 3'b010 (4 bytes).
- `arburst` output 2: constant 2'b01 (INCR).
- `arlock` output 2: constant 2'b00.
- `arcache` output 4: constant 4'b0001.
- `arprot` output 3: constant 3'b010.
- `arvalid` output 1: address valid.
- `arready` input 1: address ready.
- `rid` input 4: read ID.
- `rdata` input 32: read data.
- `rresp` input 2: read response.
- `rlast` input 1: last beat.
- `rvalid` input 1: read valid.
- `rready` output 1: = (state==DATA) && (!out_valid || out_ready).
- `out_valid` output 1: output beat valid.
- `out_data` output 32: output beat data.
- `out_last` output 1: output beat is the burst's last (copy of `rlast`).
- `out_ready` input 1: consumer ready.
- `busy` output 1: state != IDLE.
- `err` output 3: sticky: [0] rresp != OKAY, [1] rid != ARID, [2] rlast/beat-count mismatch.

## Operation
- FSM states are IDLE, ADDR and DATA. There is at most one outstanding burst.
- IDLE: when `req_valid` is high, latch addr/len, clear `err`, set beat counter to 0 and go to ADDR.
- ADDR: hold `arvalid` high with stable `araddr`/`arlen` until `arready`. Then drop `arvalid` and go to DATA.
- DATA: a beat is taken when `rvalid && rready`.
  - Load `out_data`/`out_last` and set `out_valid`.
  - Increment the 5-bit counter.
  - Update `err`.
- The burst ends on the accepted beat carrying `rlast`; the FSM goes to IDLE. Termination follows `rlast`, never the counter.
- `err[2]` is set on either of:
  - `rlast` on beat index != `arlen`;
  - beat index == `arlen` accepted without `rlast`.
- Beats beyond `arlen` are still accepted and forwarded, with `err[2]` set. The counter saturates at 16.
- Error beats (bad `rresp` or `rid`) are still forwarded; they are never dropped.
- Output register: cleared when `out_valid && out_ready` and no new beat is loaded that cycle. A simultaneous load and drain replaces the data and keeps `out_valid` high.
- A new request may be accepted while the last beat still sits in the output register. Ordering is preserved.

## Timing
- Reset values:
  - FSM: IDLE.
  - `arvalid`, `rready`, `out_valid`, `out_last`, `busy`: 0.
  - `err`, `araddr`, `arlen`, `out_data`: 0.
  - `req_ready`: 1.
  - The constant outputs hold their fixed values in reset too.
- Reset mid-burst aborts immediately: outputs return to reset values, with no completion of the AR or R handshake.
- Request accepted at edge N: `arvalid` is high after edge N.
- Minimum `arvalid` → `arready`: 0 cycles (same-cycle `arready` gives one cycle of `arvalid`).
- Beat accepted at edge M: `out_valid`/`out_data` are valid after edge M (1-cycle latency).
- Full throughput: one beat per cycle while `out_ready` stays high.
- `out_ready` low with `out_valid` high drives `rready` low in the same cycle (combinational). No beat is lost.
- `rlast` accepted at edge L: `req_ready` is high after edge L. Minimum turnaround between bursts is 1 idle cycle, the cycle with `arvalid` low.

## Structure
- Shared package `amba_axi_pkg`, used by both `amba_axi_read` and `amba_axi_write`:
  - burst type constants (FIXED/INCR/WRAP);
  - resp constants (OKAY/EXOKAY/SLVERR/DECERR);
  - default lock/cache/prot and size-4B constants;
  - FSM state enum type.
- One sub-module, `amba_axi_read_ostage`: a 33-bit (data+last) single-entry valid/ready register that exports `in_ready` for `rready`.

## Test plan
- Req addr 32'h1000, len 3, `arready` on 2nd cycle, 4 beats D0–D3 with `rlast` on D3, `out_ready` high → `araddr`=32'h1000, `arlen`=3, out beats D0–D3 each 1 cycle after acceptance, `out_last` only on D3, `err`=0, `req_ready` high after D3.
- Same burst with `out_ready` toggling 1010… → `rready` follows `out_ready`; all 4 beats delivered in order, none duplicated.
- `rresp`=2'b10 on beat 1 of a 2-beat burst → beat forwarded, `err`=3'b001 sticky through IDLE, cleared to 0 on next request acceptance.
- len 3 but `rlast` on beat 1 → FSM to IDLE after beat 1, `err[2]`=1; and the reverse case (len 1, `rlast` on beat 3) → 4 beats forwarded, `err[2]`=1.
- `rid`=4'h5 with `ARID`=0 → `err[1]`=1, data still forwarded.
- `aresetn` low while in DATA after beat 2 of 4 → `arvalid`, `rready`, `out_valid`, `busy` go to 0 asynchronously, `req_ready`=1; a new request after release completes normally.
